// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data; SYNC_FIFO_ERR_FLAGS_EN adds overflow/underflow
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  full
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok, rd_ok;
  assign empty = count == '0;
  assign full  = count == (ADDR_WIDTH+1)'(DEPTH);
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  always_ff @(posedge clk)
    if (wr_ok && rst) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      if (wr_ok != rd_ok) count <= wr_ok ? count + 1'b1 : count - 1'b1;
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       empty, full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] cnt;

  sync_fifo dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .wr_en(wr_en), .rd_en(rd_en), .empty(empty), .full(full)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic w, input logic r, input logic [3:0] d);
    wr_en = w;
    rd_en = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", 32'(data_out), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 4'(i));
      if (i == 0) check("fill_first_empty", 32'(empty), 0);
      if (i == 14) check("fill_15_full", 32'(full), 0);
      if (i == 15) check("fill_16_full", 32'(full), 1);
    end
    check("fill_full_hold", 32'(full), 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("fill_ovf_pulse", 32'(overflow), 1);
    cyc(0, 0, 0);
    check("fill_ovf_clear", 32'(overflow), 0);
`endif
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0);
      check("drain_data", 32'(data_out), 32'(i));
      check("drain_empty", 32'(empty), (i == 15) ? 1 : 0);
      check("drain_full", 32'(full), 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      check("overread_dout", 32'(data_out), 32'hF);
      check("overread_empty", 32'(empty), 1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check("overread_udf", 32'(underflow), 1);
`endif
    end
    cyc(1, 0, 4'hA);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("udf_clear", 32'(underflow), 0);
`endif
    cyc(1, 0, 4'hB);
    cyc(1, 0, 4'hC);
    cyc(1, 1, 4'hD);
    check("simul_dout", 32'(data_out), 32'hA);
    check("simul_empty", 32'(empty), 0);
    cyc(0, 1, 0);
    check("simul_rd_b", 32'(data_out), 32'hB);
    cyc(0, 1, 0);
    check("simul_rd_c", 32'(data_out), 32'hC);
    check("simul_not_empty", 32'(empty), 0);
    cyc(0, 1, 0);
    check("simul_rd_d", 32'(data_out), 32'hD);
    check("simul_empty_end", 32'(empty), 1);
    cyc(1, 1, 4'h5);
    check("empty_wr_rd_dout", 32'(data_out), 32'hD);
    check("empty_wr_rd_empty", 32'(empty), 0);
    cyc(0, 1, 0);
    check("empty_wr_rd_read", 32'(data_out), 32'h5);
    check("empty_wr_rd_end", 32'(empty), 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i) ^ 4'h5);
    check("full2_full", 32'(full), 1);
    cyc(1, 1, 4'hF);
    check("full_rw_dout", 32'(data_out), 32'h5);
    check("full_rw_full", 32'(full), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("full_rw_ovf", 32'(overflow), 1);
`endif
    cyc(0, 0, 0);
    check("full_rw_hold", 32'(full), 0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 1, 0);
      check("full_rw_drain", 32'(data_out), 32'(4'(i) ^ 4'h5));
      check("full_rw_empty", 32'(empty), (i == 15) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, 4'(i + 7));
    rst = 1'b0;
    cyc(1, 1, 4'h9);
    check("midrst_empty", 32'(empty), 1);
    check("midrst_full", 32'(full), 0);
    check("midrst_dout", 32'(data_out), 0);
    rst = 1'b1;
    cyc(0, 1, 0);
    check("midrst_rd_dout", 32'(data_out), 0);
    check("midrst_rd_empty", 32'(empty), 1);
    cnt = 4'h3;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, cnt);
      check("wrap_flags_w", 32'(empty & full), 0);
      cyc(0, 1, 0);
      check("wrap_data", 32'(data_out), 32'(cnt));
      check("wrap_empty", 32'(empty), 1);
      cnt = cnt + 4'h1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer of DATA_WIDTH-bit words, DEPTH entries deep, with registered read data and full/empty status flags. It decouples a producer and consumer running on the same clock, such as a data-path stage feeding a slower consumer. Writes are dropped when the FIFO is full, and reads are ignored when it is empty.

## Interface
- DATA_WIDTH, 4, width of each stored word
- DEPTH, 16, number of entries; must be a power of two, at least 2
- ADDR_WIDTH, 4, log2(DEPTH); pointer width
- clk  input  1  rising-edge clock for all state
- rst  input  1  reset; one clock, reset is synchronous and active-low (rst=0 sampled on a rising clk edge resets the block)
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data
- wr_en  input  1  write request
- rd_en  input  1  read request
- empty  output  1  FIFO holds zero entries
- full  output  1  FIFO holds DEPTH entries
- Port order: clk, rst, data_in, data_out, wr_en, rd_en, empty, full.

## Operation
- Storage is a DEPTH×DATA_WIDTH register array.
- Write pointer wr_ptr and read pointer rd_ptr are each ADDR_WIDTH bits and wrap naturally modulo DEPTH.
- Occupancy counter count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Write accepted = wr_en & ~full.
  - mem[wr_ptr] <= data_in
  - wr_ptr increments.
- Read accepted = rd_en & ~empty.
  - data_out <= mem[rd_ptr]
  - rd_ptr increments.
- count update:
  - +1 on write only
  - −1 on read only
  - unchanged when both or neither are accepted.
- Simultaneous wr_en & rd_en, neither flag set: both operations occur and count is unchanged.
- When full with wr_en & rd_en: only the read is accepted; the write is dropped and count decrements.
- When empty with wr_en & rd_en: only the write is accepted; data_out is unchanged.
- Write while full is dropped: memory, pointers and count are unchanged.
- Read while empty is ignored: data_out holds its last value.
- data_out holds its value in any cycle without an accepted read.
- Flags:
  - empty = (count == 0)
  - full = (count == DEPTH)
  - Both are decoded from registered count only; there is no combinational path from any input to any output.
- Reset (rst=0 at a clk edge), including mid-operation:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0
  - Result: empty=1, full=0.
  - Memory contents are not cleared; they are unreachable until rewritten.
  - Reset overrides any wr_en/rd_en in the same cycle.

## Timing
- Write latency: data written at edge N is readable from edge N+1; empty deasserts after edge N.
- Read latency: one cycle; data_out is valid after the edge on which the read is accepted.
- full asserts after the edge that accepts the DEPTH-th outstanding write.
- full deasserts after the edge that accepts the next read.
- empty asserts after the edge that accepts the read of the last entry.
- Throughput: one write and one read per cycle sustained.

## Configuration
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds output ports overflow and underflow (1 bit each), after full in the port list.
  - overflow is registered high for one cycle after an edge where wr_en=1 and the write was dropped because the FIFO was full.
  - underflow is registered high for one cycle after an edge where rd_en=1 and the FIFO was empty.
  - Both reset to 0.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst=0 for 2 edges -> empty=1, full=0, data_out=0; assert the same after a reset applied mid-stream with 5 entries stored.
- Fill past capacity: write values 0..16 on consecutive cycles with rd_en=0 -> full=1 after the 16th write. Value 16 is dropped; if SYNC_FIFO_ERR_FLAGS_EN is defined, overflow pulses once. Then read 16 times -> data_out sequence 0..15 in order; empty=1 after the last read.
- Over-read: on the empty FIFO hold rd_en=1 for 3 more cycles -> data_out stays 15 and the pointers are unchanged; underflow pulses on each attempt if the macro is enabled.
- Simultaneous access: with 3 entries (0xA, 0xB, 0xC), assert wr_en=1 with data_in=0xD and rd_en=1 for 1 cycle -> data_out=0xA, count stays 3; subsequent reads give 0xB, 0xC, 0xD.
- Full plus simultaneous read/write: at full, assert wr_en & rd_en -> read accepted, write dropped, full=0 the next cycle.
- Wrap-around: 40 cycles of interleaved single writes and reads of an incrementing counter -> every read returns the values in write order across pointer wrap; empty and full are never both 1.
